// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants, configuration checks and the pipeline
// stage record used by the pipelined adder.
package pipe_adder_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // Bits handled by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // A configuration is legal when the width is in range and splits evenly.
    function automatic bit config_legal(input int width, input int stages);
        return (stages > 0) && (width >= MIN_WIDTH) && (width <= MAX_WIDTH)
            && ((width % stages) == 0);
    endfunction

    // One in-flight transaction. Fields are sized for the widest legal
    // configuration; only the low WIDTH bits are meaningful.
    //   res : completed low result slices
    //   a/b : operands (b already inverted for subtraction)
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] res;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the source holds its payload steady while valid && !ready.
// PIPE_ADDER_OVF_EN adds the signed-overflow flag ovf next to so.
interface pipe_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] so;
    logic             co;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side (drives operands, takes results).
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, so, co
`ifdef PIPE_ADDER_OVF_EN
        , input ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, so, co
`ifdef PIPE_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/pipe_adder_slice.sv
// adder_slice: combinational W-bit adder with carry in and carry out.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] sum;

    // Full-width add; the extra top bit is the carry out.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s   = sum[W-1:0];
        co  = sum[W];
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-pipelined adder/subtractor. Stage k adds
// slice k of the operands using the carry registered by stage k-1; each
// stage register carries its whole transaction (remaining operands and
// completed low result slices). A single global advance stalls every stage
// together when the output is held.
// Optional: PIPE_ADDER_OVF_EN adds the ovf signed-overflow output.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    generate
        if (!config_legal(WIDTH, STAGES)) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be 4..64 and a multiple of STAGES");
        end
    endgenerate

    stage_t           stage_q [STAGES];
    stage_t           stage_d [STAGES];
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic [SLICE-1:0] sl_a    [STAGES];
    logic [SLICE-1:0] sl_b    [STAGES];
    logic [SLICE-1:0] sl_s    [STAGES];
    logic             sl_ci   [STAGES];
    logic             sl_co   [STAGES];

    // Pipeline moves whenever the output slot is empty or being taken.
    always_comb begin
        advance     = !stage_q[STAGES-1].valid || bus.out_ready;
        bus.in_ready = advance && !rst;
    end

    // Slice operands: stage 0 reads the bus, later stages read the record
    // held by the previous stage. Subtraction is a + ~b + 1.
    always_comb begin
        b_eff    = bus.sub ? ~bus.b : bus.b;
        sl_a[0]  = bus.a[SLICE-1:0];
        sl_b[0]  = b_eff[SLICE-1:0];
        sl_ci[0] = bus.sub ? 1'b1 : bus.ci;
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]  = stage_q[k-1].a[k*SLICE +: SLICE];
            sl_b[k]  = stage_q[k-1].b[k*SLICE +: SLICE];
            sl_ci[k] = stage_q[k-1].carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.W(SLICE)) u_slice (
            .a  (sl_a[k]),
            .b  (sl_b[k]),
            .ci (sl_ci[k]),
            .s  (sl_s[k]),
            .co (sl_co[k])
        );
    end

    // Next stage records: hold on stall, otherwise shift one stage forward.
    always_comb begin
        stage_d = stage_q;
        if (advance) begin
            stage_d[0].valid = bus.in_valid;
            stage_d[0].carry = sl_co[0];
            stage_d[0].res   = MAX_WIDTH'(sl_s[0]);
            stage_d[0].a     = MAX_WIDTH'(bus.a);
            stage_d[0].b     = MAX_WIDTH'(b_eff);
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k]                       = stage_q[k-1];
                stage_d[k].carry                 = sl_co[k];
                stage_d[k].res[k*SLICE +: SLICE] = sl_s[k];
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    // Result comes straight from the last stage record.
    always_comb begin
        bus.out_valid = stage_q[STAGES-1].valid;
        bus.so        = stage_q[STAGES-1].res[WIDTH-1:0];
        bus.co        = stage_q[STAGES-1].carry;
    end

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: operands (b as actually added) share a sign that the
    // result does not. A cleared record yields 0.
    always_comb begin
        bus.ovf = (stage_q[STAGES-1].a[WIDTH-1] == stage_q[STAGES-1].b[WIDTH-1])
               && (stage_q[STAGES-1].res[WIDTH-1] != stage_q[STAGES-1].a[WIDTH-1]);
    end
`endif

endmodule
